// File: rtl/verinject_pkg.sv
// Shared types for the fault scheduler: idle bus value, FSM states and schedule entry layout.
package verinject_pkg;

  localparam int unsigned SCHED_CYCLE_W = 32;
  localparam int unsigned SCHED_BIT_W   = 32;
  localparam int unsigned SCHED_HOLD_W  = 8;

  localparam logic [SCHED_BIT_W-1:0] IDLE_STATE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    INJECT = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [SCHED_CYCLE_W-1:0] cycle;
    logic [SCHED_BIT_W-1:0]   bit_id;
    logic [SCHED_HOLD_W-1:0]  hold;
  } sched_entry_t;

endpackage

// File: rtl/verinject_sched_fifo.sv
// Synchronous FIFO of schedule entries with registered full/empty/count.
module verinject_sched_fifo
  import verinject_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  sched_entry_t             push_data,
  input  logic                     pop,
  output sched_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sched_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;
  logic [CNT_W-1:0]   count_d;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count_d = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign head    = mem[rd_ptr];

  // Storage is not reset; occupancy tracking guards every read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/verinject_fault_scheduler.sv
// Drives the injector state bus from a queued schedule of (cycle, bit id, hold) windows.
module verinject_fault_scheduler
  import verinject_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CYCLE_W = SCHED_CYCLE_W,
  parameter int unsigned HOLD_W  = SCHED_HOLD_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     run,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [CYCLE_W-1:0]       load_cycle,
  input  logic [31:0]              load_bit,
  input  logic [HOLD_W-1:0]        load_hold,
  output logic [31:0]              verinject__injector_state,
  output logic                     injecting,
  output logic [CYCLE_W-1:0]       cycle_count,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     late,
  output logic                     bad_entry
);

  sched_state_e        state_q;
  sched_state_e        state_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_d;
  logic [31:0]         bus_d;
  logic                fire;
  logic                late_set;
  logic                last_clk;
  logic                due;
  logic                accept;
  logic                push;
  logic                bad_set;
  logic [CYCLE_W:0]    next_count;
  logic [CYCLE_W-1:0]  head_cycle;
  sched_entry_t        push_data;
  sched_entry_t        head;
  logic                fifo_full;
  logic                fifo_empty;

  assign accept     = load_valid && load_ready;
  assign push       = accept && (load_bit != IDLE_STATE);
  assign bad_set    = accept && (load_bit == IDLE_STATE);
  assign push_data  = '{cycle: SCHED_CYCLE_W'(load_cycle), bit_id: load_bit, hold: SCHED_HOLD_W'(load_hold)};
  assign load_ready = !fifo_full;

  verinject_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (fire),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending)
  );

  // Compare against cycle_count+1 so the bus change lines up with the counter reaching head.cycle.
  assign head_cycle = CYCLE_W'(head.cycle);
  assign next_count = {1'b0, cycle_count} + (CYCLE_W+1)'(1);
  assign due        = run && !fifo_empty && ({1'b0, head_cycle} <= next_count);
  assign last_clk   = (state_q == INJECT) && (hold_q == '0);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = ARMED;
      ARMED: begin
        if (due)             state_d = INJECT;
        else if (fifo_empty) state_d = IDLE;
      end
      INJECT: begin
        if (last_clk) begin
          if (due)             state_d = INJECT;
          else if (fifo_empty) state_d = IDLE;
          else                 state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fire     = due && ((state_q == ARMED) || last_clk);
    hold_d   = hold_q;
    bus_d    = verinject__injector_state;
    late_set = 1'b0;
    if (fire) begin
      hold_d   = HOLD_W'(head.hold);
      bus_d    = head.bit_id;
      late_set = (head_cycle < cycle_count);
    end else if (state_q == INJECT) begin
      if (last_clk) bus_d  = IDLE_STATE;
      else          hold_d = hold_q - HOLD_W'(1);
    end
  end

  // Output registers, window countdown, saturating run counter and sticky flags.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      hold_q                    <= '0;
      verinject__injector_state <= IDLE_STATE;
      injecting                 <= 1'b0;
      cycle_count               <= '0;
      late                      <= 1'b0;
      bad_entry                 <= 1'b0;
    end else begin
      hold_q                    <= hold_d;
      verinject__injector_state <= bus_d;
      injecting                 <= (bus_d != IDLE_STATE);
      if (run && (cycle_count != '1)) cycle_count <= cycle_count + CYCLE_W'(1);
      late                      <= late | late_set;
      bad_entry                 <= bad_entry | bad_set;
    end
  end

endmodule

// File: tb/tb_verinject_fault_scheduler.sv
// Directed bench for verinject_fault_scheduler with a queue-based reference model checked every cycle.
module tb_verinject_fault_scheduler;
  import verinject_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 32;
  localparam int unsigned HW    = 8;

  logic          clock = 1'b0;
  logic          reset_n, clear, run, load_valid, load_ready;
  logic [CW-1:0] load_cycle;
  logic [31:0]   load_bit;
  logic [HW-1:0] load_hold;
  logic [31:0]   inj_state;
  logic          injecting;
  logic [CW-1:0] cycle_count;
  logic [3:0]    pending;
  logic          late, bad_entry;

  always #5 clock = ~clock;

  verinject_fault_scheduler #(.DEPTH(DEPTH), .CYCLE_W(CW), .HOLD_W(HW)) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .clear                     (clear),
    .run                       (run),
    .load_valid                (load_valid),
    .load_ready                (load_ready),
    .load_cycle                (load_cycle),
    .load_bit                  (load_bit),
    .load_hold                 (load_hold),
    .verinject__injector_state (inj_state),
    .injecting                 (injecting),
    .cycle_count               (cycle_count),
    .pending                   (pending),
    .late                      (late),
    .bad_entry                 (bad_entry)
  );

  int total = 0;
  int nbad  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of scheduled windows plus the window/armed bookkeeping.
  typedef struct {
    logic [CW-1:0] cyc;
    logic [31:0]   bid;
    int            hold;
  } ment_t;

  ment_t         mq[$];
  logic [31:0]   m_state;
  logic [CW-1:0] m_count;
  bit            m_late, m_bad;
  int            m_phase;   // 0 waiting for work, 1 armed, 2 in a window
  int            m_remain;  // window clocks still to come after the current one
  bit            m_valid = 1'b0;

  always @(posedge clock) begin : model
    int       sz;
    bit       win_last, do_fire;
    logic [CW:0] nxt;
    if (!reset_n || clear) begin
      mq.delete();
      m_state  = IDLE_STATE;
      m_count  = '0;
      m_late   = 1'b0;
      m_bad    = 1'b0;
      m_phase  = 0;
      m_remain = 0;
    end else begin
      sz       = mq.size();
      nxt      = {1'b0, m_count} + 1;
      win_last = (m_phase == 2) && (m_remain == 0);
      do_fire  = run && (sz > 0) && ((m_phase == 1) || win_last) && ({1'b0, mq[0].cyc} <= nxt);
      if (do_fire) begin
        if (mq[0].cyc < m_count) m_late = 1'b1;
        m_state  = mq[0].bid;
        m_remain = mq[0].hold;
        m_phase  = 2;
        void'(mq.pop_front());
      end else if (m_phase == 2) begin
        if (m_remain == 0) begin
          m_state = IDLE_STATE;
          m_phase = (sz > 0) ? 1 : 0;
        end else begin
          m_remain--;
        end
      end else if (m_phase == 0 && sz > 0) begin
        m_phase = 1;
      end else if (m_phase == 1 && sz == 0) begin
        m_phase = 0;
      end
      if (load_valid && (sz < DEPTH)) begin
        if (load_bit == IDLE_STATE) m_bad = 1'b1;
        else mq.push_back('{cyc: load_cycle, bid: load_bit, hold: int'(load_hold)});
      end
      if (run && (m_count != '1)) m_count++;
    end
    m_valid = 1'b1;
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("m_state",     64'(inj_state),   64'(m_state));
      chk("m_injecting", 64'(injecting),   64'(m_state != IDLE_STATE));
      chk("m_count",     64'(cycle_count), 64'(m_count));
      chk("m_pending",   64'(pending),     64'(mq.size()));
      chk("m_ready",     64'(load_ready),  64'(mq.size() < DEPTH));
      chk("m_late",      64'(late),        64'(m_late));
      chk("m_bad",       64'(bad_entry),   64'(m_bad));
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic load(input logic [CW-1:0] c, input logic [31:0] b, input logic [HW-1:0] h);
    load_valid = 1'b1;
    load_cycle = c;
    load_bit   = b;
    load_hold  = h;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    run   = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int  win;
    bit  dropped;
    bit  seen20;
    bit  go;
    reset_n = 1'b0; clear = 1'b0; run = 1'b0; load_valid = 1'b0;
    load_cycle = '0; load_bit = '0; load_hold = '0;
    tick(); tick();
    chk("rst_state",   64'(inj_state),   64'hFFFF_FFFF);
    chk("rst_inject",  64'(injecting),   64'd0);
    chk("rst_count",   64'(cycle_count), 64'd0);
    chk("rst_ready",   64'(load_ready),  64'd1);
    chk("rst_pending", 64'(pending),     64'd0);
    reset_n = 1'b1;

    // Single one-clock window at cycle 10
    load(10, 5, 0);
    run = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("t1_state", 64'(inj_state), (cycle_count == 10) ? 64'd5 : 64'hFFFF_FFFF);
    end
    chk("t1_late", 64'(late), 64'd0);

    // Three-clock window followed back-to-back by a late entry
    do_clear();
    load(10, 5, 2);
    load(11, 7, 0);
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cycle_count >= 10 && cycle_count <= 12)
        chk("t2_state", 64'(inj_state), 64'd5);
      else if (cycle_count == 13)
        chk("t2_state", 64'(inj_state), 64'd7);
      else
        chk("t2_state", 64'(inj_state), 64'hFFFF_FFFF);
    end
    chk("t2_late", 64'(late), 64'd1);

    // Fill to capacity, then keep offering while entries drain
    do_clear();
    for (int i = 1; i <= 9; i++) begin
      load_valid = 1'b1;
      load_cycle = CW'(100 + i);
      load_bit   = 32'(i);
      load_hold  = '0;
      tick();
      chk("t3_ready",   64'(load_ready), (i < 8) ? 64'd1 : 64'd0);
      chk("t3_pending", 64'(pending),    (i < 8) ? 64'(i) : 64'd8);
    end
    load_cycle = 200; load_bit = 20; load_hold = 0;
    run = 1'b1;
    seen20 = 1'b0;
    for (int i = 0; i < 230 && cycle_count < 205; i++) begin
      go = load_ready;
      tick();
      if (go && load_valid) load_valid = 1'b0;
      if (inj_state == 32'd20) begin
        seen20 = 1'b1;
        chk("t3_at200", 64'(cycle_count), 64'd200);
      end
    end
    load_valid = 1'b0;
    chk("t3_seen20", 64'(seen20), 64'd1);

    // Window length is independent of run
    do_clear();
    load(20, 3, 3);
    run = 1'b1;
    win = 0;
    dropped = 1'b0;
    for (int i = 0; i < 60 && cycle_count < 30; i++) begin
      tick();
      if (inj_state == 32'd3) win++;
      if (!dropped && cycle_count == 21) begin
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          if (inj_state == 32'd3) win++;
        end
        chk("t4_frozen", 64'(cycle_count), 64'd21);
        run = 1'b1;
        dropped = 1'b1;
      end
    end
    chk("t4_dropped", 64'(dropped), 64'd1);
    chk("t4_window",  64'(win),     64'd4);

    // Clear in the middle of a window, then a rejected entry
    do_clear();
    load(5, 9, 10);
    load(50, 1, 0);
    run = 1'b1;
    for (int i = 0; i < 20 && !injecting; i++) tick();
    chk("t5_started", 64'(injecting), 64'd1);
    tick(); tick();
    chk("t5_pend1", 64'(pending), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    run   = 1'b0;
    chk("t5_state",   64'(inj_state), 64'hFFFF_FFFF);
    chk("t5_inject",  64'(injecting), 64'd0);
    chk("t5_pending", 64'(pending),   64'd0);
    load(0, 32'hFFFF_FFFF, 0);
    chk("t5_bad",     64'(bad_entry), 64'd1);
    chk("t5_pend0",   64'(pending),   64'd0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
